// File: rtl/alu_pkg.sv
// alu_pkg
// Shared definitions for the ALU front end: the decryptedOP operation codes
// seen by the execution units, the dispatcher FSM state type, and a helper
// that identifies shift operations (their second operand is a shift amount).
package alu_pkg;

    localparam logic [3:0] OP_ADD     = 4'd0;
    localparam logic [3:0] OP_SUB     = 4'd1;
    localparam logic [3:0] OP_SLT     = 4'd2;
    localparam logic [3:0] OP_SLTU    = 4'd3;
    localparam logic [3:0] OP_XOR     = 4'd4;
    localparam logic [3:0] OP_OR      = 4'd5;
    localparam logic [3:0] OP_AND     = 4'd6;
    localparam logic [3:0] OP_SLL     = 4'd8;
    localparam logic [3:0] OP_SRL     = 4'd12;
    localparam logic [3:0] OP_SRA     = 4'd13;
    localparam logic [3:0] OP_INVALID = 4'd15;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// alu_op_decode
// Purely combinational decode of an R/I-type integer operation into the
// 4-bit unit operation code.
// Ports:
//   funct3       in  3  RISC-V funct3
//   funct7_b5    in  1  funct7[5], selects SUB / SRA (and marks SLL illegal)
//   is_imm       in  1  I-type encoding
//   decrypted_op out 4  operation code (OP_* from alu_pkg)
//   illegal      out 1  operation is not supported
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       funct7_b5,
    input  logic       is_imm,
    output logic [3:0] decrypted_op,
    output logic       illegal
);

    // I-type funct3=000 has no SUB form: funct7_b5 there is just an
    // immediate bit, so only the register form may select SUB.
    always_comb begin
        decrypted_op = OP_INVALID;
        case (funct3)
            3'b000:  decrypted_op = (funct7_b5 && !is_imm) ? OP_SUB : OP_ADD;
            3'b001:  decrypted_op = funct7_b5 ? OP_INVALID : OP_SLL;
            3'b010:  decrypted_op = OP_SLT;
            3'b011:  decrypted_op = OP_SLTU;
            3'b100:  decrypted_op = OP_XOR;
            3'b101:  decrypted_op = funct7_b5 ? OP_SRA : OP_SRL;
            3'b110:  decrypted_op = OP_OR;
            3'b111:  decrypted_op = OP_AND;
            default: decrypted_op = OP_INVALID;
        endcase
    end

    assign illegal = (decrypted_op == OP_INVALID);

endmodule

// File: rtl/alu_dispatch.sv
// alu_dispatch
// ALU front end: accepts a decoded integer op on a valid/ready handshake,
// formats operands for the execution units, issues a one-cycle dat_ready
// strobe, captures the OR-ed unit result and presents it on an output
// valid/ready handshake.
// Ports:
//   soc_clk, reset                 clock, async active-high reset
//   in_valid/in_ready              request handshake (ready only in IDLE)
//   funct3, funct7_b5, is_imm      operation encoding
//   rs1, rs2, imm                  operands (imm already sign-extended)
//   dat_ready                      one-cycle issue strobe to the units
//   ALU_dat1, ALU_dat2             formatted operands
//   ALU_opcode, decryptedOP        registered funct3 and operation code
//   unit_result                    OR of all unit outputs
//   out_valid/out_ready            result handshake
//   result, illegal                captured result and unsupported-op flag
module alu_dispatch
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            soc_clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic            funct7_b5,
    input  logic            is_imm,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [XLEN-1:0] imm,
    output logic            dat_ready,
    output logic [XLEN-1:0] ALU_dat1,
    output logic [XLEN-1:0] ALU_dat2,
    output logic [2:0]      ALU_opcode,
    output logic [3:0]      decryptedOP,
    input  logic [XLEN-1:0] unit_result,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            illegal
);

    state_t          state;
    logic [3:0]      dec_op;
    logic            dec_illegal;
    logic [XLEN-1:0] src;
    logic [XLEN-1:0] dat2_next;

    alu_op_decode u_decode (
        .funct3       (funct3),
        .funct7_b5    (funct7_b5),
        .is_imm       (is_imm),
        .decrypted_op (dec_op),
        .illegal      (dec_illegal)
    );

    // Shifters only look at a 5-bit amount; clearing the upper bits keeps
    // the OR-combined unit bus free of stray operand bits.
    assign src       = is_imm ? imm : rs2;
    assign dat2_next = is_shift_op(dec_op) ? {{(XLEN-5){1'b0}}, src[4:0]} : src;

    // Dispatcher FSM. All outputs are registered; dat_ready is set on
    // acceptance so it is high exactly during ISSUE. The unit result is
    // only valid during WAIT (units clear once dat_ready drops), so it is
    // captured on the WAIT->DONE edge.
    always_ff @(posedge soc_clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            in_ready    <= 1'b1;
            dat_ready   <= 1'b0;
            out_valid   <= 1'b0;
            illegal     <= 1'b0;
            ALU_dat1    <= '0;
            ALU_dat2    <= '0;
            ALU_opcode  <= '0;
            decryptedOP <= '0;
            result      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        ALU_dat1    <= rs1;
                        ALU_dat2    <= dat2_next;
                        ALU_opcode  <= funct3;
                        decryptedOP <= dec_op;
                        dat_ready   <= !dec_illegal;
                        in_ready    <= 1'b0;
                        state       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    dat_ready <= 1'b0;
                    state     <= S_WAIT;
                end
                S_WAIT: begin
                    result    <= (decryptedOP == OP_INVALID) ? '0 : unit_result;
                    illegal   <= (decryptedOP == OP_INVALID);
                    out_valid <= 1'b1;
                    state     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    dat_ready <= 1'b0;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule
